// File: rtl/imem_uart_loader_if.sv
// ============================================================================
// Module  : imem_uart_loader_if
// Brief   : IMEM write port bundle driven by the UART program loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_uart_loader_if #(
    parameter int ADDR_W = 11
);
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    modport master (
        output im_we,
        output im_addr,
        output im_wdata
    );

    modport slave (
        input im_we,
        input im_addr,
        input im_wdata
    );
endinterface

`default_nettype wire

// File: rtl/imem_uart_loader.sv
// ============================================================================
// Module  : imem_uart_loader
// Brief   : Boot loader: UART 8N1 image receiver writing big-endian words to
//           IMEM while holding the CPU in reset until the image is complete.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_uart_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 11,
    parameter int MAX_WORDS    = 2048
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             rx,
    imem_uart_loader_if.master    bus,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int                 c_CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        HDR0  = 3'd0,
        HDR1  = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } ld_state_t;

    // ------------------------------------------------------------------
    // rx synchroniser (idle-high reset so no false start bit after reset)
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    rx_state_t          r_rx_state, w_rx_state_nxt;
    logic [c_CNT_W-1:0] r_rx_cnt,   w_rx_cnt_nxt;
    logic [2:0]         r_rx_bit,   w_rx_bit_nxt;
    logic [7:0]         r_rx_shift, w_rx_shift_nxt;
    logic               w_byte_vld;
    logic               w_frame_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
        end
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_byte_vld     = 1'b0;
        w_frame_err    = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (!r_rx_sync) begin
                    w_rx_state_nxt = RX_START;
                    w_rx_cnt_nxt   = '0;
                end
            end
            RX_START: begin
                if (r_rx_cnt == c_HALF_LAST) begin
                    w_rx_cnt_nxt = '0;
                    // Line back high at mid start bit: treat as a glitch
                    if (r_rx_sync) begin
                        w_rx_state_nxt = RX_IDLE;
                    end else begin
                        w_rx_state_nxt = RX_DATA;
                        w_rx_bit_nxt   = '0;
                    end
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == c_BIT_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) begin
                        w_rx_state_nxt = RX_STOP;
                    end else begin
                        w_rx_bit_nxt = r_rx_bit + 1'b1;
                    end
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == c_BIT_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_state_nxt = RX_IDLE;
                    w_byte_vld     = r_rx_sync;
                    w_frame_err    = ~r_rx_sync;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + 1'b1;
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Image loader
    // ------------------------------------------------------------------
    ld_state_t         r_state, w_state_nxt;
    logic [15:0]       r_count, w_count_nxt;
    logic [ADDR_W-1:0] r_idx,   w_idx_nxt;
    logic [1:0]        r_bcnt,  w_bcnt_nxt;
    logic [31:0]       r_wdata, w_wdata_nxt;
    logic [15:0]       w_hdr_count;

    assign w_hdr_count = {r_count[15:8], r_rx_shift};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= HDR0;
            r_count <= '0;
            r_idx   <= '0;
            r_bcnt  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_idx   <= w_idx_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_idx_nxt   = r_idx;
        w_bcnt_nxt  = r_bcnt;
        w_wdata_nxt = r_wdata;
        case (r_state)
            HDR0: begin
                if (w_frame_err) begin
                    w_state_nxt = ERR;
                end else if (w_byte_vld) begin
                    w_count_nxt = {r_rx_shift, 8'h00};
                    w_state_nxt = HDR1;
                end
            end
            HDR1: begin
                if (w_frame_err) begin
                    w_state_nxt = ERR;
                end else if (w_byte_vld) begin
                    w_count_nxt = w_hdr_count;
                    w_idx_nxt   = '0;
                    w_bcnt_nxt  = '0;
                    if (w_hdr_count == 16'd0 || 32'(w_hdr_count) > 32'(MAX_WORDS)) begin
                        w_state_nxt = ERR;
                    end else begin
                        w_state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (w_frame_err) begin
                    w_state_nxt = ERR;
                end else if (w_byte_vld) begin
                    w_wdata_nxt = {r_wdata[23:0], r_rx_shift};
                    w_bcnt_nxt  = r_bcnt + 1'b1;
                    if (r_bcnt == 2'd3) begin
                        w_state_nxt = WRITE;
                    end
                end
            end
            WRITE: begin
                w_idx_nxt = r_idx + ADDR_W'(1);
                if (32'(r_idx) + 32'd1 == 32'(r_count)) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = DATA;
                end
            end
            DONE:    w_state_nxt = DONE;
            ERR:     w_state_nxt = ERR;
            default: w_state_nxt = ERR;
        endcase
    end

    // WRITE lasts exactly one cycle, so the strobe is a decode of the state
    assign bus.im_we    = (r_state == WRITE);
    assign bus.im_addr  = r_idx;
    assign bus.im_wdata = r_wdata;
    assign busy         = (r_state == HDR1) || (r_state == DATA) || (r_state == WRITE);
    assign done         = (r_state == DONE);
    assign err          = (r_state == ERR);
    assign cpu_reset    = (r_state != DONE);

endmodule

`default_nettype wire
